// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
//
// Shared types and constants for the data-memory dump unit.
//   dump_state_t : dump sequencer states (IDLE, DUMP, DONE)
//   WORD_BYTES   : bytes per memory word at the default 64-bit data width
//   BYTE_OFF     : number of low address bits that select a byte in a word
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DEFAULT_N  = 64;
    localparam int WORD_BYTES = DEFAULT_N / 8;
    localparam int BYTE_OFF   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
//
// DEPTH x N word storage with one synchronous write port and two
// combinational read ports (core load path and dump loader).
//
// Ports:
//   clk         : write clock, rising edge
//   we          : write enable
//   waddr       : write word index
//   wdata       : write data
//   core_raddr  : core load word index
//   core_rdata  : core load data (combinational)
//   dump_raddr  : dump loader word index
//   dump_rdata  : dump loader data (combinational)
//
// Contents start at zero and are deliberately not touched by reset, so a
// core reset keeps the program's data visible for a later dump.
// ----------------------------------------------------------------------------
module dmem_array #(
    parameter int N     = 64,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] core_raddr,
    output logic [N-1:0]  core_rdata,
    input  logic [AW-1:0] dump_raddr,
    output logic [N-1:0]  dump_rdata
);

    // Declaration initialiser gives the power-up zero contents.
    logic [N-1:0] mem_q [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Both read ports see the pre-edge contents, so a register capturing
    // dump_rdata on the same edge as a store gets the old value.
    assign core_rdata = mem_q[core_raddr];
    assign dump_rdata = mem_q[dump_raddr];

endmodule : dmem_array

// File: rtl/dmem_dump_unit.sv
// ----------------------------------------------------------------------------
// dmem_dump_unit
//
// Data memory for the single-cycle ARM core, plus a dump engine that
// streams every word in index order over a valid/ready port.
//
// Ports:
//   CLOCK_50       : clock, rising edge
//   reset          : asynchronous active-low reset (memory contents survive)
//   DM_addr        : core byte address; word index = DM_addr[AW+2:3]
//   DM_writeData   : core store data
//   DM_writeEnable : core store strobe
//   DM_readData    : core load data, combinational
//   dump           : dump request level; acted on at its rising edge
//   dump_valid     : a dump word is presented
//   dump_ready     : consumer accepts the presented word
//   dump_index     : index of the presented word
//   dump_data      : snapshot of the presented word
//   dump_done      : one-cycle pulse after the last word transfers
//   busy           : high while dumping and in the done cycle
//
// Handshake: a word transfers on a rising edge where dump_valid and
// dump_ready are both high. Once dump_valid is raised, dump_valid,
// dump_index and dump_data stay constant until that transfer; only reset
// can withdraw a presented word.
// ----------------------------------------------------------------------------
module dmem_dump_unit
    import dmem_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic [N-1:0]  DM_addr,
    input  logic [N-1:0]  DM_writeData,
    input  logic          DM_writeEnable,
    output logic [N-1:0]  DM_readData,
    input  logic          dump,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_index,
    output logic [N-1:0]  dump_data,
    output logic          dump_done,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Address decode: byte offset and bits above the array are dropped,
    // so addresses wrap modulo DEPTH words.
    // ------------------------------------------------------------------
    logic [AW-1:0] core_idx;
    logic          unused_addr_bits;

    assign core_idx         = DM_addr[BYTE_OFF +: AW];
    assign unused_addr_bits = ^{DM_addr[N-1:BYTE_OFF+AW], DM_addr[BYTE_OFF-1:0]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dump_state_t   state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          dump_q, dump_d;
    logic          dump_valid_q, dump_valid_d;
    logic [N-1:0]  dump_data_q, dump_data_d;
    logic          dump_done_q, dump_done_d;
    logic          busy_q, busy_d;

    logic          dump_rise;
    logic          xfer;
    logic          load_snapshot;
    logic [N-1:0]  dump_rd_data;

    assign dump_rise = dump & ~dump_q;
    assign xfer      = dump_valid_q & dump_ready;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // The loader reads at ptr_d so the word for the next presented index
    // is captured on the same edge that moves the pointer.
    dmem_array #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk        (CLOCK_50),
        .we         (DM_writeEnable),
        .waddr      (core_idx),
        .wdata      (DM_writeData),
        .core_raddr (core_idx),
        .core_rdata (DM_readData),
        .dump_raddr (ptr_d),
        .dump_rdata (dump_rd_data)
    );

    // ------------------------------------------------------------------
    // Sequencer next-state and registered-output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        dump_d        = dump;
        dump_valid_d  = dump_valid_q;
        dump_done_d   = 1'b0;
        busy_d        = busy_q;
        load_snapshot = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only IDLE listens for a request; edges seen in DUMP or
                // DONE are dropped rather than queued.
                if (dump_rise) begin
                    state_d       = DUMP;
                    ptr_d         = '0;
                    dump_valid_d  = 1'b1;
                    busy_d        = 1'b1;
                    load_snapshot = 1'b1;
                end
            end
            DUMP: begin
                if (xfer) begin
                    if (ptr_q == LAST_IDX) begin
                        state_d      = DONE;
                        dump_valid_d = 1'b0;
                        dump_done_d  = 1'b1;
                    end else begin
                        ptr_d         = ptr_q + AW'(1);
                        load_snapshot = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d      = IDLE;
                dump_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // Snapshot register: reloaded only when a new index is presented, so
    // stores to the presented word during a stall do not disturb it.
    always_comb begin
        dump_data_d = dump_data_q;
        if (load_snapshot) begin
            dump_data_d = dump_rd_data;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            dump_q       <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            dump_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            dump_q       <= dump_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
            dump_done_q  <= dump_done_d;
            busy_q       <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dump_valid = dump_valid_q;
    assign dump_index = ptr_q;
    assign dump_data  = dump_data_q;
    assign dump_done  = dump_done_q;
    assign busy       = busy_q;

endmodule : dmem_dump_unit

// File: tb/tb_dmem_dump_unit.sv
`timescale 1ns/1ps
module tb_dmem_dump_unit;

    localparam int N     = 64;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  DM_addr = '0;
    logic [N-1:0]  DM_writeData = '0;
    logic          DM_writeEnable = 1'b0;
    logic [N-1:0]  DM_readData;
    logic          dump = 1'b0;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic [AW-1:0] dump_index;
    logic [N-1:0]  dump_data;
    logic          dump_done;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_dump_unit #(.N(N), .DEPTH(DEPTH)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .DM_writeEnable (DM_writeEnable),
        .DM_readData    (DM_readData),
        .dump           (dump),
        .dump_valid     (dump_valid),
        .dump_ready     (dump_ready),
        .dump_index     (dump_index),
        .dump_data      (dump_data),
        .dump_done      (dump_done),
        .busy           (busy)
    );

    // ---------------- clock ----------------
    always #10 CLOCK_50 = ~CLOCK_50;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic write_word(input logic [N-1:0] addr, input logic [N-1:0] data);
        DM_addr        = addr;
        DM_writeData   = data;
        DM_writeEnable = 1'b1;
        tick();
        DM_writeEnable = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        #3;
        tests_run++;
        if ({dump_valid, dump_done, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=000", {dump_valid, dump_done, busy});
        end
        tests_run++;
        if (dump_index !== '0) begin
            tests_failed++;
            $display("FAIL reset_index got=%0d exp=0", dump_index);
        end
        tests_run++;
        if (dump_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_data got=%h exp=0", dump_data);
        end
        tests_run++;
        if (DM_readData !== '0) begin
            tests_failed++;
            $display("FAIL reset_mem_zero got=%h exp=0", DM_readData);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_store_load();
        logic [N-1:0] v;
        v = 64'hDEAD_BEEF_0000_0001;
        write_word(64'h18, v);
        // Zero-cycle store-to-load: sampled right after the write edge.
        tests_run++;
        if (DM_readData !== v) begin
            tests_failed++;
            $display("FAIL load_0x18 got=%h exp=%h", DM_readData, v);
        end
        DM_addr = 64'h1F;
        #1;
        tests_run++;
        if (DM_readData !== v) begin
            tests_failed++;
            $display("FAIL load_0x1F got=%h exp=%h", DM_readData, v);
        end
        DM_addr = 64'h18 + 64'(8 * DEPTH);
        #1;
        tests_run++;
        if (DM_readData !== v) begin
            tests_failed++;
            $display("FAIL load_wrap got=%h exp=%h", DM_readData, v);
        end
        DM_addr = 64'h20;
        #1;
        tests_run++;
        if (DM_readData !== '0) begin
            tests_failed++;
            $display("FAIL load_neighbour got=%h exp=0", DM_readData);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) begin
            write_word(64'(i * 8), 64'(100 + i));
        end
    endtask

    task automatic test_full_dump();
        logic [N-1:0] exp_q[$];
        logic [N-1:0] exp;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(64'(100 + i));
        dump_ready = 1'b1;
        dump = 1'b1;
        tick();              // request edge t; word 0 now presented
        dump = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            tests_run++;
            if (dump_valid !== 1'b1 || busy !== 1'b1 || dump_index !== AW'(k)) begin
                tests_failed++;
                $display("FAIL full_word_%0d got v=%b b=%b idx=%0d exp v=1 b=1 idx=%0d",
                         k, dump_valid, busy, dump_index, k);
            end
            exp = exp_q.pop_front();
            tests_run++;
            if (dump_data !== exp) begin
                tests_failed++;
                $display("FAIL full_data_%0d got=%0d exp=%0d", k, dump_data, exp);
            end
            tick();
        end
        tests_run++;
        if ({dump_done, dump_valid, busy} !== 3'b101) begin
            tests_failed++;
            $display("FAIL full_done_cycle got done,valid,busy=%b exp=101",
                     {dump_done, dump_valid, busy});
        end
        tick();
        tests_run++;
        if ({dump_done, dump_valid, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL full_idle got done,valid,busy=%b exp=000",
                     {dump_done, dump_valid, busy});
        end
    endtask

    task automatic test_backpressure();
        int   edges   = 0;
        int   exp_idx = 0;
        int   stall   = 0;
        logic hold    = 1'b0;
        dump_ready = 1'b1;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        while (busy === 1'b1 && edges < 200) begin
            DM_writeEnable = 1'b0;
            if (hold) begin
                tests_run++;
                if (dump_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL bp_valid_drop edge=%0d got=%b exp=1", edges, dump_valid);
                end
            end
            if (dump_valid === 1'b1) begin
                tests_run++;
                if (dump_index !== AW'(exp_idx)) begin
                    tests_failed++;
                    $display("FAIL bp_index got=%0d exp=%0d", dump_index, exp_idx);
                end
                tests_run++;
                if (dump_data !== 64'(100 + exp_idx)) begin
                    tests_failed++;
                    $display("FAIL bp_data idx=%0d got=%0d exp=%0d", exp_idx, dump_data, 100 + exp_idx);
                end
            end
            if (dump_valid === 1'b1 && exp_idx == 7 && stall < 5) begin
                dump_ready = 1'b0;
                stall++;
                if (stall == 2) begin
                    DM_addr        = 64'h38;
                    DM_writeData   = 64'h55;
                    DM_writeEnable = 1'b1;
                end
            end else begin
                dump_ready = 1'b1;
            end
            hold = (dump_valid === 1'b1) && !dump_ready;
            if (dump_valid === 1'b1 && dump_ready) exp_idx++;
            tick();
            edges++;
        end
        DM_writeEnable = 1'b0;
        dump_ready = 1'b1;
        // Request edge counts as the first of DEPTH+7 cycles.
        tests_run++;
        if (edges != DEPTH + 6) begin
            tests_failed++;
            $display("FAIL bp_total_cycles got=%0d exp=%0d", edges + 1, DEPTH + 7);
        end
        tests_run++;
        if (exp_idx != DEPTH) begin
            tests_failed++;
            $display("FAIL bp_transfers got=%0d exp=%0d", exp_idx, DEPTH);
        end
        DM_addr = 64'h38;
        #1;
        tests_run++;
        if (DM_readData !== 64'h55) begin
            tests_failed++;
            $display("FAIL bp_store_landed got=%h exp=55", DM_readData);
        end
        write_word(64'h38, 64'd107);
    endtask

    task automatic test_retrigger();
        int edges = 0;
        int xfers = 0;
        dump_ready = 1'b1;
        dump = 1'b1;
        tick();
        while (busy === 1'b1 && edges < 200) begin
            if (dump_valid === 1'b1) begin
                tests_run++;
                if (dump_index !== AW'(xfers)) begin
                    tests_failed++;
                    $display("FAIL retrig_index got=%0d exp=%0d", dump_index, xfers);
                end
            end
            // Rising edges during DUMP (at word 11) and during DONE.
            if (xfers == 10 || xfers == 31) dump = 1'b0;
            else dump = 1'b1;
            if (dump_valid === 1'b1) xfers++;
            tick();
            edges++;
        end
        tests_run++;
        if (xfers != DEPTH || edges != DEPTH + 1) begin
            tests_failed++;
            $display("FAIL retrig_count got xfers=%0d edges=%0d exp xfers=%0d edges=%0d",
                     xfers, edges, DEPTH, DEPTH + 1);
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (busy !== 1'b0 || dump_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL retrig_no_restart cyc=%0d got busy=%b valid=%b exp 0 0",
                         i, busy, dump_valid);
            end
            tick();
        end
        dump = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_dump();
        int edges = 0;
        dump_ready = 1'b1;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        while (!(dump_valid === 1'b1 && dump_index === AW'(12)) && edges < 100) begin
            tick();
            edges++;
        end
        tests_run++;
        if (edges >= 100) begin
            tests_failed++;
            $display("FAIL mid_reach_12 got timeout exp index 12");
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({dump_valid, dump_done, busy} !== 3'b000 || dump_index !== '0 || dump_data !== '0) begin
            tests_failed++;
            $display("FAIL mid_async_reset got v,d,b=%b idx=%0d data=%h exp 000 0 0",
                     {dump_valid, dump_done, busy}, dump_index, dump_data);
        end
        DM_addr = 64'(12 * 8);
        #1;
        tests_run++;
        if (DM_readData !== 64'd112) begin
            tests_failed++;
            $display("FAIL mid_mem_kept got=%0d exp=112", DM_readData);
        end
        dump = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_held_in_reset got busy=%b exp=0", busy);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (dump_valid !== 1'b1 || dump_index !== '0 || dump_data !== 64'd100) begin
            tests_failed++;
            $display("FAIL mid_restart got v=%b idx=%0d data=%0d exp v=1 idx=0 data=100",
                     dump_valid, dump_index, dump_data);
        end
        dump = 1'b0;
        edges = 0;
        while (busy === 1'b1 && edges < 100) begin
            tick();
            edges++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_finish got busy=%b exp=0 (timeout)", busy);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_store_load();
        preload();
        test_full_dump();
        test_backpressure();
        test_retrigger();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_dmem_dump_unit
